// File: rtl/act_mem_pkg.sv
// Shared defaults and FSM state type for the activation-memory write loader.
// Optional feature macro used by the loader: ACT_MEM_LOADER_ZERO_PAD_EN.
package act_mem_pkg;

  localparam int DEF_WIDTH      = 512;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_P          = DEF_WIDTH / 8;
  localparam int DEF_IN_WIDTH   = 64;
  localparam int BEATS          = DEF_WIDTH / DEF_IN_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WRITE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/act_row_packer.sv
// Packs narrow stream beats into one memory row with merged byte enables.
// ACT_MEM_LOADER_ZERO_PAD_EN: a row closed by the last beat fills unwritten lanes with zero, be=1.
module act_row_packer
  import act_mem_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  parameter int P        = DEF_P
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_accept,
  input  logic [IN_WIDTH-1:0]   i_data,
  input  logic [IN_WIDTH/8-1:0] i_keep,
  input  logic                  i_last,
  input  logic                  i_clear,
  output logic [WIDTH-1:0]      o_row,
  output logic [P-1:0]          o_be,
  output logic                  o_rowFull
);

  localparam int LANES   = IN_WIDTH / 8;
  localparam int N_BEATS = WIDTH / IN_WIDTH;
  localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  logic [BEAT_W-1:0] r_beatCnt;
  logic [WIDTH-1:0]  r_row;
  logic [WIDTH-1:0]  w_rowNext;
  logic [P-1:0]      r_be;
  logic [P-1:0]      w_beNext;

  // Disabled bytes leave the previous row contents in place with be=0.
  always_comb begin
    w_rowNext = r_row;
    w_beNext  = r_be;
    for (int k = 0; k < LANES; k++) begin
      if (i_keep[k]) begin
        w_rowNext[(int'(r_beatCnt) * LANES + k) * 8 +: 8] = i_data[k * 8 +: 8];
        w_beNext[int'(r_beatCnt) * LANES + k]             = 1'b1;
      end
    end
`ifdef ACT_MEM_LOADER_ZERO_PAD_EN
    if (i_last) begin
      for (int j = 0; j < P; j++) begin
        if (!w_beNext[j]) begin
          w_rowNext[j * 8 +: 8] = 8'h00;
          w_beNext[j]           = 1'b1;
        end
      end
    end
`endif
  end

  assign o_rowFull = (r_beatCnt == BEAT_W'(N_BEATS - 1));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_beatCnt <= '0;
      r_row     <= '0;
      r_be      <= '0;
    end else if (i_clear) begin
      r_beatCnt <= '0;
      r_be      <= '0;
    end else if (i_accept) begin
      r_row <= w_rowNext;
      r_be  <= w_beNext;
      if (!(o_rowFull || i_last)) begin
        r_beatCnt <= r_beatCnt + BEAT_W'(1);
      end
    end
  end

  assign o_row = r_row;
  assign o_be  = r_be;

endmodule

// File: rtl/act_mem_loader.sv
// Write-side initiator for the banked activation memory: command + byte stream in, one port-A write per row.
// Optional feature macro (in act_row_packer): ACT_MEM_LOADER_ZERO_PAD_EN.
module act_mem_loader
  import act_mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int P          = DEF_P,
  parameter int IN_WIDTH   = DEF_IN_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [ADDR_WIDTH:0]   cmd_rows,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_WIDTH-1:0]   s_data,
  input  logic [IN_WIDTH/8-1:0] s_keep,
  input  logic                  s_last,
  output logic [ADDR_WIDTH-1:0] address_a,
  output logic [WIDTH-1:0]      data_a,
  output logic [P-1:0]          i_be_a,
  output logic [P-1:0]          i_cs_a,
  output logic                  wren_a,
  output logic                  done,
  output logic                  err_overrun
);

  state_t                r_state;
  state_t                w_stateNext;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_rows;
  logic [ADDR_WIDTH:0]   r_rowIdx;
  logic [ADDR_WIDTH:0]   w_rowIdxInc;
  logic                  r_lastSeen;
  logic                  r_errOverrun;
  logic                  w_fillAccept;
  logic                  w_rowFull;
  logic                  w_lastRow;
  logic                  w_clear;
  logic [WIDTH-1:0]      w_row;
  logic [P-1:0]          w_be;

  assign w_fillAccept = (r_state == FILL) && s_valid;
  assign w_clear      = (r_state == WRITE);
  assign w_rowIdxInc  = r_rowIdx + (ADDR_WIDTH + 1)'(1);
  assign w_lastRow    = (w_rowIdxInc == r_rows);

  act_row_packer #(
    .WIDTH    (WIDTH),
    .IN_WIDTH (IN_WIDTH),
    .P        (P)
  ) u_packer (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_accept  (w_fillAccept),
    .i_data    (s_data),
    .i_keep    (s_keep),
    .i_last    (s_last),
    .i_clear   (w_clear),
    .o_row     (w_row),
    .o_be      (w_be),
    .o_rowFull (w_rowFull)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Command context, row progress and the sticky overrun flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_base       <= '0;
      r_rows       <= '0;
      r_rowIdx     <= '0;
      r_lastSeen   <= 1'b0;
      r_errOverrun <= 1'b0;
    end else begin
      if ((r_state == IDLE) && cmd_valid) begin
        r_base       <= cmd_base_addr;
        r_rows       <= cmd_rows;
        r_rowIdx     <= '0;
        r_lastSeen   <= 1'b0;
        r_errOverrun <= 1'b0;
      end
      if (w_fillAccept) begin
        r_lastSeen <= s_last;
      end
      if (r_state == WRITE) begin
        r_rowIdx <= w_rowIdxInc;
        if (!r_lastSeen && w_lastRow) begin
          r_errOverrun <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    cmd_ready   = 1'b0;
    s_ready     = 1'b0;
    wren_a      = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_stateNext = (cmd_rows == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        s_ready = 1'b1;
        if (w_fillAccept && (w_rowFull || s_last)) begin
          w_stateNext = WRITE;
        end
      end
      WRITE: begin
        wren_a = 1'b1;
        if (r_lastSeen) begin
          w_stateNext = DONE;
        end else if (w_lastRow) begin
          w_stateNext = DRAIN;
        end else begin
          w_stateNext = FILL;
        end
      end
      DRAIN: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign address_a   = r_base + r_rowIdx[ADDR_WIDTH-1:0];
  assign data_a      = w_row;
  assign i_be_a      = w_be;
  assign i_cs_a      = wren_a ? w_be : '0;
  assign err_overrun = r_errOverrun;

endmodule

// File: tb/tb_act_mem_loader.sv
// Self-checking bench for act_mem_loader: directed cases plus randomized commands/streams against a row-level model.
// Honors ACT_MEM_LOADER_ZERO_PAD_EN in the reference model.
`timescale 1ns/1ps
module tb_act_mem_loader;

  localparam int WIDTH      = 512;
  localparam int ADDR_WIDTH = 3;
  localparam int P          = 64;
  localparam int IN_WIDTH   = 64;
  localparam int LANES      = IN_WIDTH / 8;
  localparam int ROW_BEATS  = WIDTH / IN_WIDTH;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_base_addr = '0;
  logic [ADDR_WIDTH:0]   cmd_rows = '0;
  logic                  s_valid = 1'b0;
  logic                  s_ready;
  logic [IN_WIDTH-1:0]   s_data = '0;
  logic [LANES-1:0]      s_keep = '0;
  logic                  s_last = 1'b0;
  logic [ADDR_WIDTH-1:0] address_a;
  logic [WIDTH-1:0]      data_a;
  logic [P-1:0]          i_be_a;
  logic [P-1:0]          i_cs_a;
  logic                  wren_a;
  logic                  done;
  logic                  err_overrun;

  always #5 clock = ~clock;

  act_mem_loader dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_base_addr (cmd_base_addr),
    .cmd_rows      (cmd_rows),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_keep        (s_keep),
    .s_last        (s_last),
    .address_a     (address_a),
    .data_a        (data_a),
    .i_be_a        (i_be_a),
    .i_cs_a        (i_cs_a),
    .wren_a        (wren_a),
    .done          (done),
    .err_overrun   (err_overrun)
  );

  typedef struct {
    logic [IN_WIDTH-1:0] data;
    logic [LANES-1:0]    keep;
    logic                last;
  } beat_t;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data;
    logic [P-1:0]          be;
    logic [P-1:0]          cs;
    logic                  sRdy;
  } wr_t;

  beat_t           beats[$];
  wr_t             expQ[$];
  wr_t             obsQ[$];
  logic [WIDTH-1:0] modelRow = '0;
  bit              expErr;
  int              checkCount = 0;
  int              errorCount = 0;
  int              doneCnt = 0;
  int              wrenCnt = 0;
  int              readyCnt = 0;

  // Observe one time unit after each rising edge so every sample sees settled state.
  always @(posedge clock) begin
    #1;
    if (wren_a) begin
      obsQ.push_back('{addr: address_a, data: data_a, be: i_be_a, cs: i_cs_a, sRdy: s_ready});
      wrenCnt++;
    end
    if (done) doneCnt++;
    if (s_ready) readyCnt++;
  end

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: walks the byte stream row by row, tracking the row storage bytes.
  task automatic buildExpected(input int base, input int rows);
    int          rowNo = 0;
    int          pos = 0;
    logic [P-1:0] be = '0;
    expQ.delete();
    expErr = 0;
    if (rows == 0) return;
    foreach (beats[i]) begin
      for (int k = 0; k < LANES; k++) begin
        if (beats[i].keep[k]) begin
          modelRow[(pos * LANES + k) * 8 +: 8] = beats[i].data[k * 8 +: 8];
          be[pos * LANES + k] = 1'b1;
        end
      end
      pos++;
      if (pos == ROW_BEATS || beats[i].last) begin
`ifdef ACT_MEM_LOADER_ZERO_PAD_EN
        if (beats[i].last) begin
          for (int b = 0; b < P; b++) begin
            if (!be[b]) begin
              modelRow[b * 8 +: 8] = 8'h00;
              be[b] = 1'b1;
            end
          end
        end
`endif
        expQ.push_back('{addr: ADDR_WIDTH'((base + rowNo) % (1 << ADDR_WIDTH)),
                         data: modelRow, be: be, cs: be, sRdy: 1'b0});
        rowNo++;
        pos = 0;
        be = '0;
        if (beats[i].last) break;
        if (rowNo == rows) begin
          expErr = 1;
          break;
        end
      end
    end
  endtask

  task automatic makeBeats(input int n, input bit fullKeep);
    beat_t b;
    beats.delete();
    for (int i = 0; i < n; i++) begin
      b.data = {$urandom, $urandom};
      b.keep = (fullKeep || $urandom_range(0, 3) != 0) ? 8'hFF : LANES'($urandom);
      b.last = (i == n - 1);
      beats.push_back(b);
    end
  endtask

  task automatic sendBeat(input beat_t b, output bit ok);
    ok = 0;
    s_valid = 1'b1;
    s_data  = b.data;
    s_keep  = b.keep;
    s_last  = b.last;
    for (int t = 0; t < 100; t++) begin
      if (s_ready) begin
        @(posedge clock);
        ok = 1;
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic issueCmd(input int base, input int rows, output bit ok);
    ok = 0;
    cmd_valid     = 1'b1;
    cmd_base_addr = ADDR_WIDTH'(base);
    cmd_rows      = (ADDR_WIDTH + 1)'(rows);
    for (int t = 0; t < 50; t++) begin
      if (cmd_ready) begin
        @(posedge clock);
        ok = 1;
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
    cmd_valid = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] byteMask(input logic [P-1:0] be);
    logic [WIDTH-1:0] m;
    for (int b = 0; b < P; b++) m[b * 8 +: 8] = {8{be[b]}};
    return m;
  endfunction

  // One full transaction: command, stream (unless rows==0), wait for done, compare writes.
  task automatic applyStimulus(input int base, input int rows);
    bit ok;
    int d0;
    int r0;
    int waited;
    int n;
    logic [WIDTH-1:0] m;
    buildExpected(base, rows);
    obsQ.delete();
    d0 = doneCnt;
    r0 = readyCnt;
    issueCmd(base, rows, ok);
    checkOutput("cmdAccepted", WIDTH'(ok), 1);
    if (rows != 0) begin
      foreach (beats[i]) begin
        repeat ($urandom_range(0, 2)) @(negedge clock);
        sendBeat(beats[i], ok);
        if (!ok) begin
          checkOutput("beatAccepted", 0, 1);
          break;
        end
      end
    end
    waited = 0;
    for (int t = 0; t < 100; t++) begin
      if (doneCnt > d0) break;
      @(negedge clock);
      waited++;
    end
    if (rows == 0) begin
      checkOutput("zeroRowsDoneSoon", WIDTH'(waited <= 2), 1);
      checkOutput("zeroRowsNoReady", WIDTH'(readyCnt - r0), 0);
    end
    repeat (3) @(negedge clock);
    checkOutput("doneCount", WIDTH'(doneCnt - d0), 1);
    checkOutput("writeCount", WIDTH'(obsQ.size()), WIDTH'(expQ.size()));
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      m = byteMask(expQ[i].be);
      checkOutput($sformatf("addr[%0d]", i), WIDTH'(obsQ[i].addr), WIDTH'(expQ[i].addr));
      checkOutput($sformatf("be[%0d]", i), WIDTH'(obsQ[i].be), WIDTH'(expQ[i].be));
      checkOutput($sformatf("cs[%0d]", i), WIDTH'(obsQ[i].cs), WIDTH'(expQ[i].be));
      checkOutput($sformatf("data[%0d]", i), obsQ[i].data & m, expQ[i].data & m);
      checkOutput($sformatf("sReadyInWrite[%0d]", i), WIDTH'(obsQ[i].sRdy), 0);
    end
    checkOutput("errOverrun", WIDTH'(err_overrun), WIDTH'(expErr));
    checkOutput("idleCmdReady", WIDTH'(cmd_ready), 1);
    checkOutput("idleCs", WIDTH'(i_cs_a), 0);
  endtask

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "CmdReady"}, WIDTH'(cmd_ready), 1);
    checkOutput({pfx, "SReady"}, WIDTH'(s_ready), 0);
    checkOutput({pfx, "Wren"}, WIDTH'(wren_a), 0);
    checkOutput({pfx, "Done"}, WIDTH'(done), 0);
    checkOutput({pfx, "Err"}, WIDTH'(err_overrun), 0);
    checkOutput({pfx, "Addr"}, WIDTH'(address_a), 0);
    checkOutput({pfx, "Data"}, data_a, 0);
    checkOutput({pfx, "Be"}, WIDTH'(i_be_a), 0);
    checkOutput({pfx, "Cs"}, WIDTH'(i_cs_a), 0);
  endtask

  initial begin
    bit ok;
    int w0;
    int rows;
    repeat (3) @(negedge clock);
    checkResetState("rst");
    reset_n = 1'b1;
    @(negedge clock);

    $display("[TB] two full rows at base 2");
    makeBeats(16, 1);
    applyStimulus(2, 2);

    $display("[TB] address wrap from base 7");
    makeBeats(16, 1);
    applyStimulus(7, 2);

    $display("[TB] partial row closed by s_last");
    makeBeats(3, 1);
    applyStimulus(5, 1);

    $display("[TB] stream longer than commanded rows");
    makeBeats(12, 1);
    applyStimulus(1, 1);

    $display("[TB] reset in the middle of a row");
    makeBeats(8, 1);
    issueCmd(0, 2, ok);
    checkOutput("midCmdAccepted", WIDTH'(ok), 1);
    for (int i = 0; i < 3; i++) begin
      sendBeat(beats[i], ok);
      checkOutput($sformatf("midBeat[%0d]", i), WIDTH'(ok), 1);
    end
    w0 = wrenCnt;
    reset_n = 1'b0;
    #1;
    checkResetState("midRst");
    modelRow = '0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    checkOutput("noWriteAfterReset", WIDTH'(wrenCnt - w0), 0);
    checkOutput("cmdReadyAfterReset", WIDTH'(cmd_ready), 1);

    $display("[TB] zero-row command");
    beats.delete();
    applyStimulus(4, 0);

    $display("[TB] randomized commands");
    for (int t = 0; t < 25; t++) begin
      rows = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
      makeBeats($urandom_range(1, rows * ROW_BEATS + 10), 0);
      applyStimulus($urandom_range(0, 7), rows);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
